// File: rtl/wb_sram_pkg.sv
// Shared types for the Wishbone-to-8-bit asynchronous SRAM bridge:
// FSM states, lane constants and lane-selection helpers.
package wb_sram_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR,
    ACK,
    ERR
  } state_t;

  typedef struct packed {
    logic  vld;
    lane_t idx;
  } pick_t;

  function automatic pick_t pick_low(input logic [LANES-1:0] m);
    pick_t p;
    p = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) begin
        p.vld = 1'b1;
        p.idx = lane_t'(i);
      end
    end
    return p;
  endfunction

  function automatic logic [LANES-1:0] above(input lane_t l);
    logic [LANES-1:0] m;
    m = {{(LANES-1){1'b1}}, 1'b0} << l;
    return m;
  endfunction

  function automatic logic [7:0] byte_of(
    input logic [31:0] d,
    input lane_t       l
  );
    return d[{l, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave splitting 32-bit accesses into byte SRAM cycles.
// Define WB_SRAM_ERR_EN to error out-of-range or sel=0 accesses.
module wb_sram_ctrl
  import wb_sram_pkg::*;
#(
  parameter int SRAM_AW = 17,
  parameter int WB_AW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [7:0]         sram_data,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  state_t             r_state;
  logic               r_we;
  logic [3:0]         r_sel;
  logic [31:0]        r_wdat;
  logic [SRAM_AW-3:0] r_wadr;
  lane_t              r_lane;
  logic [31:0]        r_rdat;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_ce_n;
  logic               r_we_n;
  logic               r_oe_n;
  logic               r_drv;
  logic [7:0]         r_wbyte;
  logic               r_ack;
  logic               r_err;

  logic  w_req;
  logic  w_bad;
  logic  w_unused;
  pick_t w_first;
  pick_t w_next;

  assign w_req   = wb_cyc_i & wb_stb_i;
  assign w_first = pick_low(wb_sel_i);
  assign w_next  = pick_low(r_sel & above(r_lane));

`ifdef WB_SRAM_ERR_EN
  assign w_bad    = (|wb_adr_i[WB_AW-1:SRAM_AW]) | ~w_first.vld;
  assign w_unused = ^wb_adr_i[1:0];
  assign wb_err_o = r_err & w_req;
`else
  assign w_bad    = 1'b0;
  assign w_unused = ^{wb_adr_i[WB_AW-1:SRAM_AW], wb_adr_i[1:0], r_err};
  assign wb_err_o = 1'b0;
`endif

  // responses are masked so they can never appear outside cyc&stb
  assign wb_ack_o  = r_ack & w_req;
  assign wb_dat_o  = r_rdat;
  assign sram_addr = r_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_we_n = r_we_n;
  assign sram_oe_n = r_oe_n;
  assign sram_data = r_drv ? r_wbyte : 8'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_wadr  <= '0;
      r_lane  <= '0;
      r_rdat  <= '0;
      r_addr  <= '0;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_drv   <= 1'b0;
      r_wbyte <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_we   <= wb_we_i;
            r_sel  <= wb_sel_i;
            r_wdat <= wb_dat_i;
            r_wadr <= wb_adr_i[SRAM_AW-1:2];
            r_lane <= w_first.idx;
            if (!wb_we_i && !w_bad) r_rdat <= '0;
            if (w_bad) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else if (!w_first.vld) begin
              r_state <= ACK;
              r_ack   <= 1'b1;
            end else begin
              r_addr <= {wb_adr_i[SRAM_AW-1:2], w_first.idx};
              r_ce_n <= 1'b0;
              if (wb_we_i) begin
                r_state <= WR;
                r_we_n  <= 1'b0;
                r_drv   <= 1'b1;
                r_wbyte <= byte_of(wb_dat_i, w_first.idx);
              end else begin
                r_state <= RD_ISSUE;
              end
            end
          end
        end
        RD_ISSUE: begin
          r_state <= RD_CAPT;
          r_oe_n  <= 1'b0;
        end
        RD_CAPT, WR: begin
          if (r_state == RD_CAPT) begin
            r_rdat[{r_lane, 3'b000} +: 8] <= sram_data;
            r_oe_n <= 1'b1;
          end
          // lane boundary: finish, or abort silently if the master left
          if (!wb_cyc_i || !w_next.vld) begin
            r_state <= wb_cyc_i ? ACK : IDLE;
            r_ack   <= wb_cyc_i;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_drv   <= 1'b0;
          end else begin
            r_lane  <= w_next.idx;
            r_addr  <= {r_wadr, w_next.idx};
            r_wbyte <= byte_of(r_wdat, w_next.idx);
            r_state <= r_we ? WR : RD_ISSUE;
          end
        end
        ACK, ERR: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_AW, default 17, meaning SRAM byte-address width (128 KiB device).
REQ-002 SHALL have parameter WB_AW, default 32, meaning Wishbone byte-address width.
REQ-003 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports: wb_cyc_i  input  1  bus cycle; wb_stb_i  input  1  strobe; wb_we_i  input  1  write enable.
REQ-006 SHALL have ports: wb_adr_i  input  WB_AW  byte address, bits [1:0] ignored; wb_sel_i  input  4  byte lanes; wb_dat_i  input  32  write data.
REQ-007 SHALL have ports: wb_dat_o  output  32  read data; wb_ack_o  output  1  ack; wb_err_o  output  1  error.
REQ-008 SHALL have ports: sram_addr  output  SRAM_AW  byte address; sram_data  inout  8  data; sram_ce_n, sram_we_n, sram_oe_n  output  1  active-low strobes.

Function
REQ-009 SHALL be a Wishbone classic slave translating each 32-bit access into up to four sequential 8-bit SRAM accesses, lane 0 (bits 7:0) first.
REQ-010 SHALL form sram_addr = {wb_adr_i[SRAM_AW-1:2], lane[1:0]}.
REQ-011 SHALL use states IDLE, RD_ISSUE, RD_CAPT, WR, ACK; IDLE -> RD_ISSUE/WR on cyc&stb sampled high, lane = lowest set sel bit.
REQ-012 RD_ISSUE (1 cycle): ce_n=0, we_n=1, oe_n=1, address driven; SRAM registers byte at this edge.
REQ-013 RD_CAPT (1 cycle): ce_n=0, we_n=1, oe_n=0, same address; controller captures sram_data into wb_dat_o lane at end of cycle.
REQ-014 WR (1 cycle per lane): ce_n=0, we_n=0, oe_n=1, sram_data driven with selected byte of wb_dat_i; sram_data SHALL be high-Z in every other state.
REQ-015 Lanes with sel=0 SHALL be skipped (no SRAM strobe); their wb_dat_o bytes SHALL read 0.
REQ-016 After last selected lane SHALL enter ACK: wb_ack_o=1 for exactly one cycle, then IDLE.
REQ-017 Latency: full-word read acks in cycle 9 after request sampled (cycle 0); full-word write acks in cycle 5; each skipped lane removes 2 (read) or 1 (write) cycles.
REQ-018 wb_dat_i, wb_sel_i, wb_adr_i, wb_we_i SHALL be latched in IDLE on acceptance; later changes ignored.
REQ-019 wb_dat_o SHALL hold last read value until next read acceptance clears it.
REQ-020 wb_cyc_i low during RD_*/WR SHALL abort at lane boundary: current SRAM cycle completes, remaining lanes skipped, no ack, return to IDLE.
REQ-021 sel=0 with WB_SRAM_ERR_EN undefined SHALL go directly IDLE -> ACK with no SRAM activity.
REQ-022 Never more than one of ack/err high; never asserted outside cyc&stb.

Reset
REQ-023 rst_n low at a clock edge SHALL force IDLE, ce_n=we_n=oe_n=1, sram_addr=0, wb_dat_o=0, ack=err=0, sram_data high-Z, regardless of state (mid-access aborted, partial writes not undone).

Configuration
REQ-024 Macro WB_SRAM_ERR_EN defined: accesses with wb_adr_i[WB_AW-1:SRAM_AW] nonzero or sel=0 SHALL go IDLE -> ERR response (wb_err_o=1 one cycle, no SRAM strobe).
REQ-025 Macro WB_SRAM_ERR_EN undefined: wb_err_o SHALL be tied 0, upper address bits ignored (aliasing).

Structure
REQ-026 Package wb_sram_pkg SHALL hold the state enum, LANES=4 constant and lane-index type.
REQ-027 No sub-module; single flat FSM plus datapath registers.

Verification
REQ-028 Write 0xA1B2C3D4 sel=1111 to 0x100 -> four WR cycles at sram_addr 0x100..0x103 data D4,C3,B2,A1; ack in cycle 5.
REQ-029 Read 0x100 after REQ-028 -> wb_dat_o=0xA1B2C3D4, ack in cycle 9, oe_n low only in RD_CAPT.
REQ-030 Write sel=0100 data 0x00EE0000 to 0x200 then read sel=1111 -> only 0x202 written; read lane 2 = 0xEE.
REQ-031 Drop wb_cyc_i during lane-1 write -> lanes 2,3 not written, no ack, IDLE next cycle.
REQ-032 rst_n low during RD_CAPT -> next cycle all strobes 1, ack 0, sram_data high-Z.
REQ-033 With WB_SRAM_ERR_EN: access 0x0002_0000 -> wb_err_o one cycle, no ce_n pulse; without: aliases to SRAM 0x00000 with ack.
